jt5205_player: RTL and testbench

//  ROM sample sequencer for the jt5205 ADPCM decoder. Fetches packed ADPCM bytes from a start..end
//  ROM range, splits each byte into two nibbles and presents one nibble on din per decoder sample

---
 rtl/jt5205_pkg.sv | 17 +
 rtl/jt5205_player_if.sv | 10 +
 rtl/jt5205_fetch.sv | 93 +++++++++
 rtl/jt5205_player.sv | 152 +++++++++++++++
 tb/tb_jt5205_player.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jt5205_pkg.sv
// Shared definitions for the jt5205 ROM sample player: FSM states and nibble selection.
package jt5205_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_PLAY  = 2'd2
  } state_t;

  // second=0 picks the nibble played first; hi_first chooses which half that is
  function automatic logic [3:0] nibble_sel(input logic [7:0] b,
                                            input logic       second,
                                            input logic       hi_first);
    nibble_sel = (second ^ hi_first) ? b[7:4] : b[3:0];
  endfunction

endpackage

// File: rtl/jt5205_player_if.sv
// ROM/SDRAM request port between the player (master) and the memory arbiter (slave).
interface jt5205_player_if #(parameter int AW = 16) ();
  logic          rom_cs;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic          rom_ok;

  modport master (output rom_cs, output rom_addr, input rom_data, input rom_ok);
  modport slave  (input rom_cs, input rom_addr, output rom_data, output rom_ok);
endinterface

// File: rtl/jt5205_fetch.sv
// ROM request handshake plus a one-byte lookahead buffer; walks addr from start to last inclusive.
module jt5205_fetch
  import jt5205_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [AW-1:0] load_addr_i,
  input  logic [AW-1:0] last_addr_i,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic          consume_i,
  jt5205_player_if.master rom,
  output logic [7:0]    next_byte_o,
  output logic          next_valid_o,
  output logic          next_last_o
);

  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] last_q, last_d;
  logic          cs_q, cs_d;
  logic          nvalid_q, nvalid_d;
  logic          all_q, all_d;
  logic [7:0]    nbyte_q, nbyte_d;
  logic          nlast_q, nlast_d;
  logic          take;
  logic          at_last;

  assign take    = cs_q & rom.rom_ok;
  assign at_last = (addr_q == last_q);

  // all_q marks that the last byte has been fetched, so a full 2^AW range still terminates
  always_comb begin
    addr_d   = addr_q;
    last_d   = last_q;
    cs_d     = cs_q;
    nvalid_d = nvalid_q;
    all_d    = all_q;
    nbyte_d  = nbyte_q;
    nlast_d  = nlast_q;
    if (clr_i || load_i) begin
      cs_d     = 1'b0;
      nvalid_d = 1'b0;
      all_d    = 1'b0;
      if (load_i) begin
        addr_d = load_addr_i;
        last_d = last_addr_i;
      end
    end else begin
      if (take) begin
        cs_d     = 1'b0;
        nbyte_d  = rom.rom_data;
        nlast_d  = at_last;
        all_d    = at_last;
        nvalid_d = 1'b1;
        addr_d   = addr_q + {{(AW-1){1'b0}}, 1'b1};
      end else if (en_i && !cs_q && !nvalid_q && !all_q) begin
        cs_d = 1'b1;
      end
      if (consume_i) nvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      last_q   <= '0;
      cs_q     <= 1'b0;
      nvalid_q <= 1'b0;
      all_q    <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      last_q   <= last_d;
      cs_q     <= cs_d;
      nvalid_q <= nvalid_d;
      all_q    <= all_d;
    end
  end

  always_ff @(posedge clk) begin
    nbyte_q <= nbyte_d;
    nlast_q <= nlast_d;
  end

  assign rom.rom_cs   = cs_q;
  assign rom.rom_addr = addr_q;
  assign next_byte_o  = nbyte_q;
  assign next_valid_o = nvalid_q;
  assign next_last_o  = nlast_q;

endmodule

// File: rtl/jt5205_player.sv
// Sequences packed ADPCM bytes from ROM into jt5205 nibbles, one per decoder sample strobe.
module jt5205_player
  import jt5205_pkg::*;
#(
  parameter int AW       = 16,
  parameter int HI_FIRST = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic [AW-1:0] start_addr_i,
  input  logic [AW-1:0] end_addr_i,
  input  logic          sample_stb_i,
  jt5205_player_if.master rom,
  output logic [3:0]    din_o,
  output logic          adpcm_rst_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          underrun_o
);

  localparam logic HI = (HI_FIRST != 0);

  state_t     state_q, state_d;
  logic [7:0] cur_q, cur_d;
  logic       cur_last_q, cur_last_d;
  logic       cur_valid_q, cur_valid_d;
  logic       phase_q, phase_d;
  logic [3:0] din_q, din_d;
  logic       arst_q, arst_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       urun_q, urun_d;

  logic       load, consume;
  logic [7:0] next_byte;
  logic       next_valid, next_last;

  jt5205_fetch #(.AW(AW)) u_fetch (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load),
    .load_addr_i (start_addr_i),
    .last_addr_i (end_addr_i),
    .clr_i       (stop_i),
    .en_i        (state_q != ST_IDLE),
    .consume_i   (consume),
    .rom         (rom),
    .next_byte_o (next_byte),
    .next_valid_o(next_valid),
    .next_last_o (next_last)
  );

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    cur_last_d  = cur_last_q;
    cur_valid_d = cur_valid_q;
    phase_d     = phase_q;
    din_d       = din_q;
    done_d      = 1'b0;
    urun_d      = urun_q;
    load        = 1'b0;
    consume     = 1'b0;
    if (stop_i) begin
      state_d     = ST_IDLE;
      cur_valid_d = 1'b0;
      din_d       = 4'd0;
    end else if (start_i) begin
      state_d     = ST_PRIME;
      load        = 1'b1;
      urun_d      = 1'b0;
      cur_valid_d = 1'b0;
      phase_d     = 1'b0;
      din_d       = 4'd0;
    end else if (state_q == ST_IDLE) begin
      din_d = 4'd0;
    end else if (!cur_valid_q) begin
      // waiting for a byte: take it straight from the lookahead buffer when it lands
      if (next_valid) begin
        cur_d       = next_byte;
        cur_last_d  = next_last;
        cur_valid_d = 1'b1;
        consume     = 1'b1;
        state_d     = ST_PLAY;
        phase_d     = 1'b0;
        if (sample_stb_i) begin
          din_d   = nibble_sel(next_byte, 1'b0, HI);
          phase_d = 1'b1;
        end
      end else if (sample_stb_i) begin
        urun_d = 1'b1;
        din_d  = 4'd0;
      end
    end else if (sample_stb_i) begin
      din_d = nibble_sel(cur_q, phase_q, HI);
      if (!phase_q) begin
        phase_d = 1'b1;
      end else begin
        phase_d = 1'b0;
        if (cur_last_q) begin
          state_d     = ST_IDLE;
          done_d      = 1'b1;
          cur_valid_d = 1'b0;
        end else if (next_valid) begin
          cur_d      = next_byte;
          cur_last_d = next_last;
          consume    = 1'b1;
        end else begin
          cur_valid_d = 1'b0;
        end
      end
    end
    busy_d = (state_d != ST_IDLE);
    arst_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cur_valid_q <= 1'b0;
      phase_q     <= 1'b0;
      din_q       <= 4'd0;
      arst_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      urun_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_valid_q <= cur_valid_d;
      phase_q     <= phase_d;
      din_q       <= din_d;
      arst_q      <= arst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      urun_q      <= urun_d;
    end
  end

  always_ff @(posedge clk) begin
    cur_q      <= cur_d;
    cur_last_q <= cur_last_d;
  end

  assign din_o       = din_q;
  assign adpcm_rst_o = arst_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign underrun_o  = urun_q;

endmodule

// File: tb/tb_jt5205_player.sv
// Randomised and directed bench for jt5205_player against a ROM-range nibble model.
module tb_jt5205_player;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic          stop_i = 1'b0;
  logic [AW-1:0] start_addr_i = '0;
  logic [AW-1:0] end_addr_i = '0;
  logic          sample_stb_i = 1'b0;
  logic [3:0]    din_o;
  logic          adpcm_rst_o, busy_o, done_o, underrun_o;

  always #5 clk = ~clk;

  jt5205_player_if #(.AW(AW)) rom ();

  jt5205_player #(.AW(AW), .HI_FIRST(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .start_addr_i(start_addr_i),
    .end_addr_i  (end_addr_i),
    .sample_stb_i(sample_stb_i),
    .rom         (rom),
    .din_o       (din_o),
    .adpcm_rst_o (adpcm_rst_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .underrun_o  (underrun_o)
  );

  int total = 0;
  int bad = 0;

  logic [7:0]    mem [0:65535];
  int            lat = 0;
  logic          bogus = 1'b0;
  logic [AW-1:0] req_log [$];
  logic          req_active = 1'b0;
  int            wcnt = 0;
  logic [AW-1:0] req_addr = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // memory model: fixed latency per request, rom_ok pulses optionally while idle
  initial begin
    rom.rom_ok   = 1'b0;
    rom.rom_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!rom.rom_cs) begin
        req_active   = 1'b0;
        rom.rom_ok   = bogus;
        rom.rom_data = 8'hFF;
      end else begin
        rom.rom_ok = 1'b0;
        if (!req_active) begin
          req_active = 1'b1;
          wcnt       = lat;
          req_addr   = rom.rom_addr;
          req_log.push_back(rom.rom_addr);
        end else begin
          check("addr_stable", 32'(rom.rom_addr), 32'(req_addr));
        end
        if (wcnt == 0) begin
          rom.rom_ok   = 1'b1;
          rom.rom_data = mem[rom.rom_addr];
        end else begin
          wcnt--;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [AW-1:0] s, input logic [AW-1:0] e);
    start_addr_i = s;
    end_addr_i   = e;
    start_i      = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic strobe();
    sample_stb_i = 1'b1;
    tick();
    sample_stb_i = 1'b0;
  endtask

  // plays start..end inclusive with one strobe every p cycles and checks the full transaction
  task automatic play_range(input logic [AW-1:0] s, input logic [AW-1:0] e, input int p);
    logic [3:0]    exp [$];
    logic [AW-1:0] addrs [$];
    logic [AW-1:0] a;
    logic [7:0]    b;
    a = s;
    for (int n = 0; n < 65536; n++) begin
      b = mem[a];
      addrs.push_back(a);
      exp.push_back(b[7:4]);
      exp.push_back(b[3:0]);
      if (a == e) break;
      a = a + 1'b1;
    end
    req_log.delete();
    pulse_start(s, e);
    check("cs_low_at_start", 32'(rom.rom_cs), 32'd0);
    check("busy_after_start", 32'(busy_o), 32'd1);
    check("arst_released", 32'(adpcm_rst_o), 32'd0);
    check("underrun_cleared", 32'(underrun_o), 32'd0);
    tick();
    check("cs_rise", 32'(rom.rom_cs), 32'd1);
    check("first_addr", 32'(rom.rom_addr), 32'(s));
    repeat (p - 2) tick();
    for (int i = 0; i < exp.size(); i++) begin
      if (i > 0) repeat (p - 1) tick();
      strobe();
      check("din", 32'(din_o), 32'(exp[i]));
      check("done_timing", 32'(done_o), (i == exp.size() - 1) ? 32'd1 : 32'd0);
    end
    tick();
    check("done_one_cycle", 32'(done_o), 32'd0);
    check("busy_end", 32'(busy_o), 32'd0);
    check("arst_end", 32'(adpcm_rst_o), 32'd1);
    check("din_idle", 32'(din_o), 32'd0);
    check("no_underrun", 32'(underrun_o), 32'd0);
    check("req_count", 32'(req_log.size()), 32'(addrs.size()));
    for (int i = 0; i < addrs.size() && i < req_log.size(); i++)
      check("req_addr", 32'(req_log[i]), 32'(addrs[i]));
  endtask

  initial begin
    logic [3:0]    got [$];
    logic [3:0]    want [$];
    logic          seen_done;
    logic [AW-1:0] rs;
    int            len;

    for (int a = 0; a < 65536; a++) mem[a] = 8'((a * 37 + 11) ^ (a >> 8));

    // reset values
    repeat (3) tick();
    check("rst_cs", 32'(rom.rom_cs), 32'd0);
    check("rst_addr", 32'(rom.rom_addr), 32'd0);
    check("rst_din", 32'(din_o), 32'd0);
    check("rst_arst", 32'(adpcm_rst_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_underrun", 32'(underrun_o), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // two bytes, high nibble first
    mem[16'h0100] = 8'h12;
    mem[16'h0101] = 8'h34;
    lat = 2;
    play_range(16'h0100, 16'h0101, 10);

    // single-byte range
    mem[16'h0020] = 8'hA5;
    lat = 1;
    play_range(16'h0020, 16'h0020, 8);

    // wrap through address 0
    lat = 0;
    play_range(16'hFFFF, 16'h0001, 8);

    // slow ROM: underrun with din forced to 0, then recovery
    mem[16'h0200] = 8'h9C;
    mem[16'h0201] = 8'h7B;
    lat = 40;
    pulse_start(16'h0200, 16'h0201);
    got.delete();
    seen_done = 1'b0;
    for (int k = 0; k < 30 && !seen_done; k++) begin
      repeat (7) tick();
      strobe();
      if (k == 0) begin
        check("underrun_din0", 32'(din_o), 32'd0);
        check("underrun_flag", 32'(underrun_o), 32'd1);
      end
      if (din_o != 4'd0) got.push_back(din_o);
      if (done_o) seen_done = 1'b1;
    end
    check("underrun_done", 32'(seen_done), 32'd1);
    check("underrun_sticky", 32'(underrun_o), 32'd1);
    want = '{4'h9, 4'hC, 4'h7, 4'hB};
    check("underrun_len", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4 && i < got.size(); i++) check("underrun_seq", 32'(got[i]), 32'(want[i]));
    tick();

    // stop in the middle of byte 0x0105
    lat = 1;
    pulse_start(16'h0105, 16'h0108);
    repeat (8) tick();
    strobe();
    check("stop_first_nib", 32'(din_o), 32'(mem[16'h0105] >> 4));
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    check("stop_busy", 32'(busy_o), 32'd0);
    check("stop_cs", 32'(rom.rom_cs), 32'd0);
    check("stop_arst", 32'(adpcm_rst_o), 32'd1);
    check("stop_din", 32'(din_o), 32'd0);
    seen_done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (done_o || rom.rom_cs) seen_done = 1'b1;
      strobe();
    end
    check("stop_quiet", 32'(seen_done), 32'd0);

    // start and stop together from idle
    start_addr_i = 16'h0500;
    end_addr_i   = 16'h0501;
    start_i      = 1'b1;
    stop_i       = 1'b1;
    tick();
    start_i = 1'b0;
    stop_i  = 1'b0;
    check("ss_busy", 32'(busy_o), 32'd0);
    check("ss_arst", 32'(adpcm_rst_o), 32'd1);
    tick();
    check("ss_cs", 32'(rom.rom_cs), 32'd0);

    // restart while playing
    mem[16'h0300] = 8'h11;
    mem[16'h0301] = 8'h22;
    mem[16'h0400] = 8'h5E;
    mem[16'h0401] = 8'h6D;
    lat = 3;
    pulse_start(16'h0300, 16'h0303);
    repeat (10) tick();
    strobe();
    check("rs_old_nib", 32'(din_o), 32'h1);
    repeat (2) tick();
    pulse_start(16'h0400, 16'h0401);
    check("rs_addr", 32'(rom.rom_addr), 32'h0400);
    check("rs_din_clear", 32'(din_o), 32'd0);
    tick();
    check("rs_cs", 32'(rom.rom_cs), 32'd1);
    want = '{4'h5, 4'hE, 4'h6, 4'hD};
    for (int i = 0; i < 4; i++) begin
      repeat (11) tick();
      strobe();
      check("rs_din", 32'(din_o), 32'(want[i]));
    end
    check("rs_done", 32'(done_o), 32'd1);
    tick();

    // async reset in mid-playback
    lat = 2;
    pulse_start(16'h0600, 16'h0603);
    repeat (8) tick();
    strobe();
    rst_n = 1'b0;
    #2;
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_cs", 32'(rom.rom_cs), 32'd0);
    check("arst_out", 32'(adpcm_rst_o), 32'd1);
    check("arst_din", 32'(din_o), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // random ranges, latencies, and stray rom_ok while no request is open
    for (int it = 0; it < 10; it++) begin
      rs    = AW'($urandom);
      len   = $urandom_range(1, 5);
      lat   = $urandom_range(0, 10);
      bogus = 1'($urandom_range(0, 1));
      play_range(rs, rs + AW'(len - 1), lat + 8);
      bogus = 1'b0;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
